sd_sector_arbiter: RTL and testbench
====================================

Name: sd_sector_arbiter

Overview:
Shares the single SD SPI sector reader between two requesters: the audio streaming controller (port A, high priority) and the chart loader (port B), which fetches the note chart from SD instead of ROM. It sequences one sector transaction at a time. It issues the reader's start pulse and sector number, steers the 512-byte read stream and the done pulse to the owning requester, and bounds each transaction with a watchdog. It sits between the requesters and sd_spi_sector_reader, in the 25.125 MHz clock domain.

Parameters:
TIMEOUT_CYCLES, 2000000, watchdog limit in CLK cycles per transaction (~80 ms).
STARVE_LIMIT, 4, consecutive A grants with B pending before B is forced next.

Ports:
CLK  in  1  system clock, 25.125 MHz.
RESET  in  1  asynchronous, active-high reset.
card_ready  in  1  reader initialised (card_stat reached ready state); no start issued while low.
a_req  in  1  audio request; level, held until a_done or a_err.
a_sector  in  32  audio sector number; stable while a_req high.
a_grant  out  1  high while A owns the reader.
a_rvalid  out  1  forwarded byte strobe for A.
a_rdata  out  8  forwarded byte for A.
a_done  out  1  1-cycle pulse when A's sector completes.
a_err  out  1  1-cycle pulse when A's transaction times out.
b_req, b_sector, b_grant, b_rvalid, b_rdata, b_done, b_err  (same widths and meaning as A, for the chart loader).
rd_start  out  1  1-cycle start pulse to the reader.
rd_sector  out  32  sector number to the reader; registered at grant.
rd_done  in  1  reader transaction-complete pulse.
rd_rvalid  in  1  reader byte strobe.
rd_rdata  in  8  reader byte.
busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async assert): state IDLE. All outputs 0, rd_sector 0, starve counter 0, watchdog 0.
- States: IDLE -> ISSUE -> WAIT -> RELEASE -> IDLE.
- IDLE:
  - Arbitrate only when card_ready=1.
  - If a_req only, pick A. If b_req only, pick B.
  - If both: pick A, unless starve_cnt == STARVE_LIMIT, then pick B.
  - On grant, latch the owner and latch the owner's sector into rd_sector, set its grant, go to ISSUE.
- Starve counter:
  - Increments on an A grant while b_req=1.
  - Clears on a B grant, or on an A grant with b_req=0.
  - Saturates at STARVE_LIMIT.
- ISSUE: rd_start=1 for exactly one cycle, clear watchdog, go to WAIT. The start pulse comes 2 cycles after the req is sampled in IDLE.
- WAIT:
  - rd_rvalid/rd_rdata are forwarded combinationally to the owner's rvalid/rdata. The non-owner's rvalid is held 0 and its rdata 0.
  - Watchdog increments each cycle.
  - On rd_done: owner's done pulses the next cycle (registered), go to RELEASE.
  - If the watchdog reaches TIMEOUT_CYCLES-1 with no rd_done: owner's err pulses, go to RELEASE.
  - If rd_rvalid and rd_done arrive in the same cycle, the byte is forwarded and done still pulses.
- RELEASE: grant drops. Stay one cycle so the requester can drop or change req, then go to IDLE. Minimum back-to-back spacing is therefore 1 idle cycle.
- Requester dropping req mid-transaction: ignored. The transaction runs to done or timeout, and done/err still pulse.
- card_ready falling mid-transaction: ignored. The watchdog bounds the transaction.
- rd_done outside WAIT: ignored. rd_rvalid outside WAIT: not forwarded.
- Exactly one of a_grant/b_grant may be high at a time.
- Watchdog width is $clog2(TIMEOUT_CYCLES+1).

Optional Feature:
Macro SD_SECTOR_ARB_STATS_EN.
- Defined: adds outputs a_count[15:0], b_count[15:0] and err_count[7:0].
  - a_count and b_count increment on each a_done and b_done respectively, and wrap.
  - err_count increments on any err and saturates at 255.
  - All three clear on RESET.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Test Plan:
- A only, a_sector=0x100, reader returns 512 bytes then rd_done -> rd_start one cycle with rd_sector=0x100; 512 a_rvalid, 0 b_rvalid; a_done one pulse; busy low 2 cycles after the done pulse.
- a_req and b_req held continuously, STARVE_LIMIT=4 -> grant sequence A,A,A,A,B,A,A,A,A,B.
- B granted, a_req raised mid-WAIT -> B completes undisturbed (b_done); A granted in the next IDLE.
- card_ready=0 with a_req=1 for 100 cycles -> no rd_start, a_grant stays 0; card_ready=1 -> rd_start 2 cycles later.
- TIMEOUT_CYCLES=50, reader never sends rd_done -> a_err pulse; no a_done; return to IDLE; next b_req is served normally.
- RESET asserted mid-WAIT -> all outputs 0 immediately; after release, a_req pending -> fresh rd_start issued.

Source files
------------

// File: rtl/sd_sector_arbiter.sv
// Two-requester arbiter for the SD sector reader: A has priority, B is forced after
// STARVE_LIMIT consecutive A grants. Optional statistics counters under SD_SECTOR_ARB_STATS_EN.
module sd_sector_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 2000000,
    parameter int unsigned STARVE_LIMIT   = 4
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        card_ready,
    input  logic        a_req,
    input  logic [31:0] a_sector,
    output logic        a_grant,
    output logic        a_rvalid,
    output logic [7:0]  a_rdata,
    output logic        a_done,
    output logic        a_err,
    input  logic        b_req,
    input  logic [31:0] b_sector,
    output logic        b_grant,
    output logic        b_rvalid,
    output logic [7:0]  b_rdata,
    output logic        b_done,
    output logic        b_err,
    output logic        rd_start,
    output logic [31:0] rd_sector,
    input  logic        rd_done,
    input  logic        rd_rvalid,
    input  logic [7:0]  rd_rdata,
`ifdef SD_SECTOR_ARB_STATS_EN
    output logic [15:0] a_count,
    output logic [15:0] b_count,
    output logic [7:0]  err_count,
`endif
    output logic        busy
);

    localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned SC_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [SC_W-1:0] SC_MAX  = SC_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StRelease} state_t;

    state_t            r_state, w_state_d;
    logic              r_owner_b, w_owner_b_d;
    logic              r_a_grant, w_a_grant_d;
    logic              r_b_grant, w_b_grant_d;
    logic [31:0]       r_rd_sector, w_rd_sector_d;
    logic              r_rd_start, w_rd_start_d;
    logic              r_a_done, w_a_done_d;
    logic              r_b_done, w_b_done_d;
    logic              r_a_err, w_a_err_d;
    logic              r_b_err, w_b_err_d;
    logic [SC_W-1:0]   r_starve, w_starve_d;
    logic [WD_W-1:0]   r_wd, w_wd_d;

    logic              w_pick_b;
    logic              w_fwd_a;
    logic              w_fwd_b;

    // B wins a tie only once A has starved it STARVE_LIMIT times in a row.
    assign w_pick_b = b_req && (!a_req || (r_starve == SC_MAX));

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state     <= StIdle;
            r_owner_b   <= 1'b0;
            r_a_grant   <= 1'b0;
            r_b_grant   <= 1'b0;
            r_rd_sector <= 32'h0;
            r_rd_start  <= 1'b0;
            r_a_done    <= 1'b0;
            r_b_done    <= 1'b0;
            r_a_err     <= 1'b0;
            r_b_err     <= 1'b0;
            r_starve    <= '0;
            r_wd        <= '0;
        end else begin
            r_state     <= w_state_d;
            r_owner_b   <= w_owner_b_d;
            r_a_grant   <= w_a_grant_d;
            r_b_grant   <= w_b_grant_d;
            r_rd_sector <= w_rd_sector_d;
            r_rd_start  <= w_rd_start_d;
            r_a_done    <= w_a_done_d;
            r_b_done    <= w_b_done_d;
            r_a_err     <= w_a_err_d;
            r_b_err     <= w_b_err_d;
            r_starve    <= w_starve_d;
            r_wd        <= w_wd_d;
        end
    end

    always_comb begin
        w_state_d     = r_state;
        w_owner_b_d   = r_owner_b;
        w_a_grant_d   = r_a_grant;
        w_b_grant_d   = r_b_grant;
        w_rd_sector_d = r_rd_sector;
        w_rd_start_d  = 1'b0;
        w_a_done_d    = 1'b0;
        w_b_done_d    = 1'b0;
        w_a_err_d     = 1'b0;
        w_b_err_d     = 1'b0;
        w_starve_d    = r_starve;
        w_wd_d        = r_wd;

        case (r_state)
            StIdle: begin
                if (card_ready && (a_req || b_req)) begin
                    w_owner_b_d   = w_pick_b;
                    w_a_grant_d   = !w_pick_b;
                    w_b_grant_d   = w_pick_b;
                    w_rd_sector_d = w_pick_b ? b_sector : a_sector;
                    if (w_pick_b || !b_req) begin
                        w_starve_d = '0;
                    end else if (r_starve != SC_MAX) begin
                        w_starve_d = r_starve + SC_W'(1);
                    end
                    w_state_d = StIssue;
                end
            end
            StIssue: begin
                w_rd_start_d = 1'b1;
                w_wd_d       = '0;
                w_state_d    = StWait;
            end
            StWait: begin
                if (rd_done) begin
                    w_a_done_d  = !r_owner_b;
                    w_b_done_d  = r_owner_b;
                    w_a_grant_d = 1'b0;
                    w_b_grant_d = 1'b0;
                    w_state_d   = StRelease;
                end else if (r_wd == WD_LAST) begin
                    w_a_err_d   = !r_owner_b;
                    w_b_err_d   = r_owner_b;
                    w_a_grant_d = 1'b0;
                    w_b_grant_d = 1'b0;
                    w_state_d   = StRelease;
                end else begin
                    w_wd_d = r_wd + WD_W'(1);
                end
            end
            StRelease: begin
                // One dead cycle lets the requester retire or change its request.
                w_state_d = StIdle;
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    assign w_fwd_a = (r_state == StWait) && !r_owner_b;
    assign w_fwd_b = (r_state == StWait) && r_owner_b;

    assign a_grant   = r_a_grant;
    assign b_grant   = r_b_grant;
    assign a_rvalid  = w_fwd_a && rd_rvalid;
    assign b_rvalid  = w_fwd_b && rd_rvalid;
    assign a_rdata   = w_fwd_a ? rd_rdata : 8'h00;
    assign b_rdata   = w_fwd_b ? rd_rdata : 8'h00;
    assign a_done    = r_a_done;
    assign b_done    = r_b_done;
    assign a_err     = r_a_err;
    assign b_err     = r_b_err;
    assign rd_start  = r_rd_start;
    assign rd_sector = r_rd_sector;
    assign busy      = (r_state != StIdle);

`ifdef SD_SECTOR_ARB_STATS_EN
    logic [15:0] r_a_count;
    logic [15:0] r_b_count;
    logic [7:0]  r_err_count;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_a_count   <= 16'h0;
            r_b_count   <= 16'h0;
            r_err_count <= 8'h0;
        end else begin
            if (r_a_done) begin
                r_a_count <= r_a_count + 16'd1;
            end
            if (r_b_done) begin
                r_b_count <= r_b_count + 16'd1;
            end
            if ((r_a_err || r_b_err) && (r_err_count != 8'hFF)) begin
                r_err_count <= r_err_count + 8'd1;
            end
        end
    end

    assign a_count   = r_a_count;
    assign b_count   = r_b_count;
    assign err_count = r_err_count;
`endif

endmodule

// File: tb/tb_sd_sector_arbiter.sv
// Self-checking bench for sd_sector_arbiter: transaction-timeline reference model,
// directed scenarios with literal expectations, then randomized traffic.
module tb_sd_sector_arbiter;

    localparam int TO     = 600;
    localparam int STARVE = 4;

    localparam int SigADone  = 0;
    localparam int SigBDone  = 1;
    localparam int SigAErr   = 2;
    localparam int SigAGrant = 3;
    localparam int SigBGrant = 4;
    localparam int SigIdle   = 5;

    logic        CLK;
    logic        RESET;
    logic        card_ready;
    logic        a_req, b_req;
    logic [31:0] a_sector, b_sector;
    logic        a_grant, a_rvalid, a_done, a_err;
    logic        b_grant, b_rvalid, b_done, b_err;
    logic [7:0]  a_rdata, b_rdata;
    logic        rd_start;
    logic [31:0] rd_sector;
    logic        rd_done, rd_rvalid;
    logic [7:0]  rd_rdata;
    logic        busy;

    sd_sector_arbiter #(
        .TIMEOUT_CYCLES(TO),
        .STARVE_LIMIT  (STARVE)
    ) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .card_ready(card_ready),
        .a_req     (a_req),
        .a_sector  (a_sector),
        .a_grant   (a_grant),
        .a_rvalid  (a_rvalid),
        .a_rdata   (a_rdata),
        .a_done    (a_done),
        .a_err     (a_err),
        .b_req     (b_req),
        .b_sector  (b_sector),
        .b_grant   (b_grant),
        .b_rvalid  (b_rvalid),
        .b_rdata   (b_rdata),
        .b_done    (b_done),
        .b_err     (b_err),
        .rd_start  (rd_start),
        .rd_sector (rd_sector),
        .rd_done   (rd_done),
        .rd_rvalid (rd_rvalid),
        .rd_rdata  (rd_rdata),
        .busy      (busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int checks   = 0;
    int failures = 0;

    // Reference model: owner (0 none, 1 A, 2 B), cycles since grant, finished flag.
    int          m_owner  = 0;
    int          m_age    = 0;
    bit          m_fin    = 1'b0;
    bit          m_err    = 1'b0;
    int          m_streak = 0;
    logic [31:0] m_sector = 32'h0;
    bit          m_pick_b;

    always_comb m_pick_b = b_req && (!a_req || (m_streak >= STARVE));

    always @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            m_owner  <= 0;
            m_age    <= 0;
            m_fin    <= 1'b0;
            m_err    <= 1'b0;
            m_streak <= 0;
            m_sector <= 32'h0;
        end else if (m_owner != 0) begin
            if (m_fin) begin
                m_owner <= 0;
                m_fin   <= 1'b0;
                m_err   <= 1'b0;
            end else if (m_age >= 1 && rd_done) begin
                m_fin <= 1'b1;
            end else if (m_age == TO) begin
                m_fin <= 1'b1;
                m_err <= 1'b1;
            end else begin
                m_age <= m_age + 1;
            end
        end else if (card_ready && (a_req || b_req)) begin
            m_owner  <= m_pick_b ? 2 : 1;
            m_age    <= 0;
            m_sector <= m_pick_b ? b_sector : a_sector;
            if (m_pick_b || !b_req) m_streak <= 0;
            else if (m_streak < STARVE) m_streak <= m_streak + 1;
        end
    end

    // Event monitor: counts and timestamps observed at the falling edge.
    int          cyc = 0;
    int          n_a_rv = 0, n_b_rv = 0, n_start = 0, n_a_done = 0, n_b_done = 0;
    int          last_start_cyc = 0, last_err_cyc = 0;
    logic [31:0] last_start_sector = 32'h0;
    byte         glog[$];
    bit          prev_a = 1'b0, prev_b = 1'b0;

    always @(negedge CLK) begin
        cyc <= cyc + 1;
        if (a_rvalid) n_a_rv <= n_a_rv + 1;
        if (b_rvalid) n_b_rv <= n_b_rv + 1;
        if (a_done) n_a_done <= n_a_done + 1;
        if (b_done) n_b_done <= n_b_done + 1;
        if (rd_start) begin
            n_start           <= n_start + 1;
            last_start_cyc    <= cyc + 1;
            last_start_sector <= rd_sector;
        end
        if (a_err || b_err) last_err_cyc <= cyc + 1;
        if (a_grant && !prev_a) glog.push_back(8'h41);
        if (b_grant && !prev_b) glog.push_back(8'h42);
        prev_a <= a_grant;
        prev_b <= b_grant;
    end

    // Reader stand-in.
    int cfg_nbytes = 4;
    bit cfg_to     = 1'b0;
    bit cfg_gaps   = 1'b0;
    bit cfg_stray  = 1'b0;
    int rdr_left   = 0;
    bit rdr_act    = 1'b0;
    bit rdr_to     = 1'b0;

    initial begin
        rd_done   = 1'b0;
        rd_rvalid = 1'b0;
        rd_rdata  = 8'h00;
        forever begin
            @(posedge CLK);
            #1;
            rd_done   = 1'b0;
            rd_rvalid = 1'b0;
            rd_rdata  = 8'h00;
            if (RESET) begin
                rdr_act = 1'b0;
            end else begin
                if (rd_start) begin
                    rdr_act  = 1'b1;
                    rdr_left = cfg_nbytes;
                    rdr_to   = cfg_to;
                end
                if (rdr_act) begin
                    if (rdr_to) begin
                        if (!busy) rdr_act = 1'b0;
                        else if ($urandom % 3 == 0) begin
                            rd_rvalid = 1'b1;
                            rd_rdata  = 8'($urandom);
                        end
                    end else if (rdr_left > 0) begin
                        if (!cfg_gaps || ($urandom % 3 != 0)) begin
                            rd_rvalid = 1'b1;
                            rd_rdata  = 8'($urandom);
                            rdr_left  = rdr_left - 1;
                        end
                    end else begin
                        rd_done = 1'b1;
                        if (cfg_gaps && ($urandom % 2 == 0)) begin
                            rd_rvalid = 1'b1;
                            rd_rdata  = 8'($urandom);
                        end
                        rdr_act = 1'b0;
                    end
                end else if (cfg_stray) begin
                    rd_rvalid = ($urandom % 5 == 0);
                    rd_rdata  = 8'($urandom);
                    rd_done   = ($urandom % 7 == 0);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_outputs();
        bit live, fa, fb;
        live = (m_owner != 0) && !m_fin;
        fa   = live && (m_owner == 1) && (m_age >= 1);
        fb   = live && (m_owner == 2) && (m_age >= 1);
        check("busy", busy, m_owner != 0);
        check("a_grant", a_grant, live && m_owner == 1);
        check("b_grant", b_grant, live && m_owner == 2);
        check("rd_start", rd_start, live && m_age == 1);
        check("rd_sector", rd_sector, m_sector);
        check("a_done", a_done, m_owner == 1 && m_fin && !m_err);
        check("b_done", b_done, m_owner == 2 && m_fin && !m_err);
        check("a_err", a_err, m_owner == 1 && m_fin && m_err);
        check("b_err", b_err, m_owner == 2 && m_fin && m_err);
        check("a_rvalid", a_rvalid, fa && rd_rvalid);
        check("b_rvalid", b_rvalid, fb && rd_rvalid);
        check("a_rdata", a_rdata, fa ? rd_rdata : 8'h00);
        check("b_rdata", b_rdata, fb ? rd_rdata : 8'h00);
    endtask

    task automatic tick();
        @(negedge CLK);
        compare_outputs();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic sig(input int which);
        case (which)
            SigADone:  return a_done;
            SigBDone:  return b_done;
            SigAErr:   return a_err;
            SigAGrant: return a_grant;
            SigBGrant: return b_grant;
            default:   return !busy;
        endcase
    endfunction

    task automatic wait_sig(input string name, input int which, input int bound);
        for (int i = 0; i < bound; i++) begin
            if (sig(which)) break;
            tick();
        end
        check(name, sig(which), 1'b1);
    endtask

    initial begin
        int    s0, s1, s2, s3, c0, g0;
        string exp_seq;
        RESET      = 1'b1;
        card_ready = 1'b0;
        a_req      = 1'b0;
        b_req      = 1'b0;
        a_sector   = 32'h0;
        b_sector   = 32'h0;
        tick();
        tick();
        check("rst_a_grant", a_grant, 1'b0);
        check("rst_b_grant", b_grant, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_rd_start", rd_start, 1'b0);
        check("rst_rd_sector", rd_sector, 32'h0);
        RESET = 1'b0;

        // A alone, full 512-byte sector.
        cfg_nbytes = 512;
        card_ready = 1'b1;
        tick();
        s0 = n_a_rv; s1 = n_b_rv; s2 = n_start; s3 = n_a_done;
        a_sector = 32'h100;
        a_req    = 1'b1;
        c0       = cyc;
        tick();
        wait_sig("t1_a_done", SigADone, 800);
        a_req = 1'b0;
        tick();
        check("t1_busy_done_plus1", busy, 1'b0);
        tick();
        check("t1_busy_done_plus2", busy, 1'b0);
        check("t1_a_rvalid_count", n_a_rv - s0, 512);
        check("t1_b_rvalid_count", n_b_rv - s1, 0);
        check("t1_start_count", n_start - s2, 1);
        check("t1_start_sector", last_start_sector, 32'h100);
        check("t1_start_latency", last_start_cyc - c0, 3);
        check("t1_a_done_count", n_a_done - s3, 1);

        // Both held: starvation guard.
        cfg_nbytes = 4;
        exp_seq    = "AAAABAAAAB";
        g0         = glog.size();
        a_sector   = 32'h1A;
        b_sector   = 32'h1B;
        a_req      = 1'b1;
        b_req      = 1'b1;
        for (int i = 0; i < 400 && glog.size() < g0 + 10; i++) tick();
        a_req = 1'b0;
        b_req = 1'b0;
        check("t2_grant_count", glog.size() >= g0 + 10, 1'b1);
        for (int i = 0; i < 10; i++) begin
            if (g0 + i < glog.size()) check("t2_grant_seq", glog[g0+i], exp_seq[i]);
        end
        wait_sig("t2_idle", SigIdle, 100);

        // B in flight, A arrives mid-WAIT.
        cfg_nbytes = 20;
        b_sector   = 32'h2000;
        b_req      = 1'b1;
        wait_sig("t3_b_grant", SigBGrant, 20);
        repeat (5) tick();
        a_sector = 32'h300;
        a_req    = 1'b1;
        wait_sig("t3_b_done", SigBDone, 100);
        b_req = 1'b0;
        c0    = cyc;
        check("t3_a_not_granted", a_grant, 1'b0);
        wait_sig("t3_a_grant", SigAGrant, 10);
        check("t3_a_grant_gap", cyc - c0, 2);
        check("t3_a_sector", rd_sector, 32'h300);
        wait_sig("t3_a_done", SigADone, 100);
        a_req = 1'b0;
        tick();

        // Card not ready holds off arbitration.
        card_ready = 1'b0;
        a_sector   = 32'h444;
        a_req      = 1'b1;
        s0         = n_start;
        g0         = glog.size();
        repeat (100) tick();
        check("t4_no_start", n_start - s0, 0);
        check("t4_no_grant", glog.size() - g0, 0);
        check("t4_a_grant_low", a_grant, 1'b0);
        card_ready = 1'b1;
        c0         = cyc;
        for (int i = 0; i < 10 && n_start == s0; i++) tick();
        check("t4_start_latency", last_start_cyc - c0, 3);
        check("t4_start_sector", last_start_sector, 32'h444);
        wait_sig("t4_a_done", SigADone, 100);
        a_req = 1'b0;
        tick();

        // Watchdog expiry, then B served normally.
        cfg_to   = 1'b1;
        a_sector = 32'h555;
        a_req    = 1'b1;
        s3       = n_a_done;
        wait_sig("t5_a_err", SigAErr, TO + 50);
        a_req  = 1'b0;
        cfg_to = 1'b0;
        tick();
        check("t5_err_latency", last_err_cyc - last_start_cyc, TO);
        check("t5_no_a_done", n_a_done - s3, 0);
        wait_sig("t5_idle", SigIdle, 10);
        b_sector = 32'h666;
        b_req    = 1'b1;
        wait_sig("t5_b_done", SigBDone, 100);
        b_req = 1'b0;
        check("t5_b_sector", last_start_sector, 32'h666);
        tick();

        // Asynchronous reset in the middle of a transfer.
        cfg_nbytes = 200;
        a_sector   = 32'h777;
        a_req      = 1'b1;
        s0         = n_start;
        for (int i = 0; i < 10 && n_start == s0; i++) tick();
        repeat (10) tick();
        #2;
        RESET = 1'b1;
        #1;
        check("t6_a_grant", a_grant, 1'b0);
        check("t6_busy", busy, 1'b0);
        check("t6_rd_sector", rd_sector, 32'h0);
        check("t6_a_rvalid", a_rvalid, 1'b0);
        tick();
        tick();
        RESET = 1'b0;
        s0    = n_start;
        for (int i = 0; i < 10 && n_start == s0; i++) tick();
        check("t6_restart", n_start - s0, 1);
        check("t6_restart_sector", last_start_sector, 32'h777);
        wait_sig("t6_a_done", SigADone, 300);
        a_req = 1'b0;
        tick();

        // Randomized traffic with stray reader strobes and occasional timeouts.
        cfg_stray = 1'b1;
        cfg_gaps  = 1'b1;
        for (int n = 0; n < 6000; n++) begin
            cfg_nbytes = $urandom_range(1, 12);
            cfg_to     = ($urandom % 50 == 0);
            if ($urandom % 20 == 0) card_ready = ($urandom % 4 != 0);
            if (a_done || a_err) a_req = 1'b0;
            else if (!a_req && ($urandom % 4 == 0)) begin
                a_req    = 1'b1;
                a_sector = $urandom;
            end else if (a_req && a_grant && ($urandom % 64 == 0)) a_req = 1'b0;
            if (b_done || b_err) b_req = 1'b0;
            else if (!b_req && ($urandom % 4 == 0)) begin
                b_req    = 1'b1;
                b_sector = $urandom;
            end else if (b_req && b_grant && ($urandom % 64 == 0)) b_req = 1'b0;
            tick();
        end
        a_req     = 1'b0;
        b_req     = 1'b0;
        cfg_stray = 1'b0;
        cfg_to    = 1'b0;
        wait_sig("final_idle", SigIdle, TO + 50);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
